// File: rtl/pkt_freelist_mgr_pkg.sv
// Shared constants and types for the packet-buffer free-list manager.
// Holds the slot ID width, the buffer address width and the free-list FSM states.
package pkt_freelist_mgr_pkg;

    localparam int PKT_AWIDTH_DEF    = 9;
    localparam int PKTBUF_AWIDTH_DEF = PKT_AWIDTH_DEF + 5;

    typedef enum logic [1:0] {
        FL_INIT,
        FL_PREFETCH,
        FL_RUN
    } fl_state_e;

    // Each slot is 32 flits, so a slot's first flit address is id << 5.
    function automatic logic [PKTBUF_AWIDTH_DEF-1:0] slot_base(input logic [PKT_AWIDTH_DEF-1:0] id);
        return {id, 5'd0};
    endfunction

endpackage

// File: rtl/pkt_freelist_mgr_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, one priority flop.
// When both request, the port that was not granted last wins.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic prio;  // 0: port 0 preferred, 1: port 1 preferred

    always_comb begin
        gnt[0] = en & req[0] & (~req[1] | ~prio);
        gnt[1] = en & req[1] & (~req[0] | prio);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      prio <= 1'b0;
        else if (gnt[0]) prio <= 1'b1;
        else if (gnt[1]) prio <= 1'b0;
    end

endmodule

// File: rtl/pkt_freelist_mgr.sv
// Free-list allocator for packet-buffer slots: loads every ID at reset, serves them
// FIFO through a show-ahead head register and takes releases from two ports.
module pkt_freelist_mgr
    import pkt_freelist_mgr_pkg::*;
#(
    parameter int PKT_AWIDTH = PKT_AWIDTH_DEF,
    parameter int RAM_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  init_done,
    output logic [PKT_AWIDTH-1:0] emptylist_out_data,
    output logic                  emptylist_out_valid,
    input  logic                  emptylist_out_ready,
    input  logic                  ret0_valid,
    input  logic [PKT_AWIDTH-1:0] ret0_id,
    output logic                  ret0_ready,
    input  logic                  ret1_valid,
    input  logic [PKT_AWIDTH-1:0] ret1_id,
    output logic                  ret1_ready,
    output logic [PKT_AWIDTH:0]   free_count,
    output logic [PKT_AWIDTH:0]   min_free,
    input  logic                  clr_stats,
    output logic                  underflow_err,
    output logic                  overflow_err
);

    localparam int                  NUM_PKTS = 1 << PKT_AWIDTH;
    localparam logic [PKT_AWIDTH:0] FULL     = (PKT_AWIDTH+1)'(NUM_PKTS);
    localparam logic [PKT_AWIDTH-1:0] LAST   = PKT_AWIDTH'(NUM_PKTS - 1);

    if (RAM_LAT != 1) begin : g_ram_lat_chk
        $error("pkt_freelist_mgr: only RAM_LAT=1 is supported");
    end

    fl_state_e             state, state_nxt;
    logic [PKT_AWIDTH-1:0] mem [NUM_PKTS];
    logic [PKT_AWIDTH-1:0] rd_ptr, wr_ptr, wr_data, acc_id, head_data;
    logic [PKT_AWIDTH:0]   ram_cnt;
    logic                  head_valid, run, full, pop, accept, byp, ram_wr, ram_rd;
    logic [1:0]            gnt;

    // FSM: state register / next state / outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FL_INIT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            FL_INIT:     if (wr_ptr == LAST) state_nxt = FL_PREFETCH;
            FL_PREFETCH: state_nxt = FL_RUN;
            default:     state_nxt = FL_RUN;
        endcase
    end

    always_comb begin
        run       = (state == FL_RUN);
        init_done = run;
    end

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (run & ~full),
        .req   ({ret1_valid, ret0_valid}),
        .gnt   (gnt)
    );

    // The head register counts as free, so a full pool is RAM (NUM_PKTS-1) + head.
    always_comb begin
        free_count = ram_cnt + (PKT_AWIDTH+1)'(head_valid);
        full       = (free_count == FULL);
        pop        = run & head_valid & emptylist_out_ready;
        accept     = |gnt;
        acc_id     = gnt[1] ? ret1_id : ret0_id;
        byp        = accept & (~head_valid | (pop & (ram_cnt == '0)));
        ram_wr     = (state == FL_INIT) | (accept & ~byp);
        ram_rd     = (state == FL_PREFETCH) | (pop & (ram_cnt != '0));
        wr_data    = (state == FL_INIT) ? wr_ptr : acc_id;
    end

    assign ret0_ready          = gnt[0];
    assign ret1_ready          = gnt[1];
    assign emptylist_out_valid = head_valid;
    assign emptylist_out_data  = head_data;

    always_ff @(posedge clk) begin
        if (ram_wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            ram_cnt    <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else begin
            if (ram_wr) wr_ptr <= wr_ptr + 1'b1;
            if (ram_rd) rd_ptr <= rd_ptr + 1'b1;
            unique case ({ram_wr, ram_rd})
                2'b10:   ram_cnt <= ram_cnt + 1'b1;
                2'b01:   ram_cnt <= ram_cnt - 1'b1;
                default: ram_cnt <= ram_cnt;
            endcase
            if (ram_rd) begin
                head_valid <= 1'b1;
                head_data  <= mem[rd_ptr];
            end else if (byp) begin
                head_valid <= 1'b1;
                head_data  <= acc_id;
            end else if (pop) begin
                head_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_free      <= FULL;
            underflow_err <= 1'b0;
            overflow_err  <= 1'b0;
        end else if (clr_stats) begin
            min_free      <= free_count;
            underflow_err <= 1'b0;
            overflow_err  <= 1'b0;
        end else begin
            if (run && free_count < min_free)               min_free      <= free_count;
            if (run && emptylist_out_ready && !head_valid)  underflow_err <= 1'b1;
            if (run && full && (ret0_valid || ret1_valid))  overflow_err  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pkt_freelist_mgr.sv
// Directed bench for pkt_freelist_mgr: init load, drain, refill, arbitration,
// concurrent pop/release, error flags and mid-stream reset.
module tb_pkt_freelist_mgr;

    localparam int AW  = 9;
    localparam int NUM = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          init_done;
    logic [AW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          ret0_valid, ret1_valid;
    logic [AW-1:0] ret0_id, ret1_id;
    logic          ret0_ready, ret1_ready;
    logic [AW:0]   free_count, min_free;
    logic          clr_stats;
    logic          underflow_err, overflow_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pkt_freelist_mgr #(.PKT_AWIDTH(AW), .RAM_LAT(1)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .init_done           (init_done),
        .emptylist_out_data  (out_data),
        .emptylist_out_valid (out_valid),
        .emptylist_out_ready (out_ready),
        .ret0_valid          (ret0_valid),
        .ret0_id             (ret0_id),
        .ret0_ready          (ret0_ready),
        .ret1_valid          (ret1_valid),
        .ret1_id             (ret1_id),
        .ret1_ready          (ret1_ready),
        .free_count          (free_count),
        .min_free            (min_free),
        .clr_stats           (clr_stats),
        .underflow_err       (underflow_err),
        .overflow_err        (overflow_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; out_ready = 1'b0; clr_stats = 1'b0;
        ret0_valid = 1'b0; ret1_valid = 1'b0; ret0_id = '0; ret1_id = '0;
        repeat (3) tick();
        n_cmp++;
        if ({init_done, out_valid, out_data, free_count, ret0_ready, ret1_ready, underflow_err, overflow_err} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got init=%0b valid=%0b data=%0d free=%0d err=%0b%0b, want all 0",
                     init_done, out_valid, out_data, free_count, underflow_err, overflow_err);
        end
        n_cmp++;
        if (min_free !== NUM) begin
            n_bad++; $display("FAIL reset_min_free: got %0d want %0d", min_free, NUM);
        end
    endtask

    // rst_n is released in cycle 1; init_done must be high in cycle NUM+2 and not before.
    task automatic test_init;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (100) tick();
        ret0_valid = 1'b1; ret0_id = 9'd3;
        #1;
        n_cmp++;
        if (ret0_ready !== 1'b0) begin
            n_bad++; $display("FAIL init_no_grant: got ready=%0b want 0", ret0_ready);
        end
        ret0_valid = 1'b0;
        repeat (412) tick();
        n_cmp++;
        if (init_done !== 1'b0) begin
            n_bad++; $display("FAIL init_done_early: got %0b want 0 after %0d cycles", init_done, NUM);
        end
        tick();
        n_cmp++;
        if (init_done !== 1'b1 || out_valid !== 1'b1 || out_data !== 9'd0 || free_count !== NUM || min_free !== NUM) begin
            n_bad++;
            $display("FAIL init_done: got done=%0b valid=%0b data=%0d free=%0d min=%0d want 1 1 0 %0d %0d",
                     init_done, out_valid, out_data, free_count, min_free, NUM, NUM);
        end
    endtask

    task automatic test_drain;
        int bad = 0;
        int first = -1;
        out_ready = 1'b1;
        for (int i = 0; i < NUM; i++) begin
            if (out_valid !== 1'b1 || out_data !== i[AW-1:0]) begin
                bad++; if (first < 0) first = i;
            end
            tick();
        end
        out_ready = 1'b0;
        n_cmp++;
        if (bad != 0) begin
            n_bad++; $display("FAIL drain_order: %0d wrong pops, first at index %0d, want ids 0..%0d", bad, first, NUM-1);
        end
        n_cmp++;
        if (out_valid !== 1'b0 || free_count !== '0 || underflow_err !== 1'b0) begin
            n_bad++; $display("FAIL drain_empty: got valid=%0b free=%0d uf=%0b want 0 0 0", out_valid, free_count, underflow_err);
        end
        tick();
        n_cmp++;
        if (min_free !== '0) begin
            n_bad++; $display("FAIL drain_min_free: got %0d want 0", min_free);
        end
    endtask

    task automatic test_refill;
        ret1_valid = 1'b1; ret1_id = 9'd37;
        #1;
        n_cmp++;
        if (ret1_ready !== 1'b1 || ret0_ready !== 1'b0) begin
            n_bad++; $display("FAIL refill_grant: got r0=%0b r1=%0b want 0 1", ret0_ready, ret1_ready);
        end
        tick();
        ret1_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 9'd37 || free_count !== 10'd1) begin
            n_bad++; $display("FAIL refill_head: got valid=%0b data=%0d free=%0d want 1 37 1", out_valid, out_data, free_count);
        end
    endtask

    task automatic test_arbitration;
        int exp_a[4] = '{37, 5, 9, 5};
        int exp_b[5] = '{9, 5, 9, 5, 9};
        int bad = 0;
        ret0_id = 9'd5; ret1_id = 9'd9;
        // Phase A: both ports request while the consumer pops every cycle.
        ret0_valid = 1'b1; ret1_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (ret0_ready !== (k % 2 == 0) || ret1_ready !== (k % 2 == 1) || out_data !== exp_a[k][AW-1:0]) begin
                bad++; $display("FAIL arb_pop_grant: k=%0d got r0=%0b r1=%0b data=%0d want r0=%0b data=%0d",
                                k, ret0_ready, ret1_ready, out_data, (k % 2 == 0), exp_a[k]);
            end
            tick();
        end
        ret0_valid = 1'b0; ret1_valid = 1'b0; out_ready = 1'b0;
        n_cmp++;
        if (bad != 0) n_bad++;
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 9'd9 || free_count !== 10'd1) begin
            n_bad++; $display("FAIL arb_phase_a_end: got valid=%0b data=%0d free=%0d want 1 9 1", out_valid, out_data, free_count);
        end
        // Phase B: no pops, releases land in the RAM in grant order.
        bad = 0;
        ret0_valid = 1'b1; ret1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (ret0_ready !== (k % 2 == 0) || ret1_ready !== (k % 2 == 1)) begin
                bad++; $display("FAIL arb_grant: k=%0d got r0=%0b r1=%0b", k, ret0_ready, ret1_ready);
            end
            tick();
        end
        ret0_valid = 1'b0; ret1_valid = 1'b0;
        n_cmp++;
        if (bad != 0) n_bad++;
        n_cmp++;
        if (free_count !== 10'd5) begin
            n_bad++; $display("FAIL arb_free: got %0d want 5", free_count);
        end
        bad = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (out_valid !== 1'b1 || out_data !== exp_b[k][AW-1:0]) begin
                bad++; $display("FAIL arb_order: k=%0d got %0d want %0d", k, out_data, exp_b[k]);
            end
            tick();
        end
        out_ready = 1'b0;
        n_cmp++;
        if (bad != 0) n_bad++;
        n_cmp++;
        if (out_valid !== 1'b0 || free_count !== '0) begin
            n_bad++; $display("FAIL arb_empty: got valid=%0b free=%0d want 0 0", out_valid, free_count);
        end
    endtask

    task automatic test_concurrent;
        int bad = 0;
        int exp;
        ret0_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            ret0_id = 9'(100 + k);
            tick();
        end
        ret0_valid = 1'b0;
        n_cmp++;
        if (free_count !== 10'd200) begin
            n_bad++; $display("FAIL conc_fill: got %0d want 200", free_count);
        end
        ret0_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            ret0_id = 9'(300 + k);
            #1;
            if (out_data !== 9'(100 + k) || free_count !== 10'd200) begin
                bad++; $display("FAIL conc_step: k=%0d got data=%0d free=%0d want %0d 200", k, out_data, free_count, 100 + k);
            end
            tick();
        end
        ret0_valid = 1'b0; out_ready = 1'b0;
        n_cmp++;
        if (bad != 0) n_bad++;
        n_cmp++;
        if (free_count !== 10'd200) begin
            n_bad++; $display("FAIL conc_free: got %0d want 200", free_count);
        end
        bad = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            exp = (k < 190) ? 110 + k : 300 + (k - 190);
            if (out_valid !== 1'b1 || out_data !== exp[AW-1:0]) bad++;
            tick();
        end
        out_ready = 1'b0;
        n_cmp++;
        if (bad != 0 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL conc_order: %0d wrong pops, valid after=%0b want 0", bad, out_valid);
        end
    endtask

    task automatic test_errors;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (underflow_err !== 1'b1 || overflow_err !== 1'b0 || free_count !== '0 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL underflow: got uf=%0b of=%0b free=%0d valid=%0b want 1 0 0 0",
                              underflow_err, overflow_err, free_count, out_valid);
        end
        ret1_valid = 1'b1;
        for (int k = 0; k < NUM; k++) begin
            ret1_id = 9'(k);
            tick();
        end
        ret1_valid = 1'b0;
        n_cmp++;
        if (free_count !== NUM || overflow_err !== 1'b0) begin
            n_bad++; $display("FAIL fill_full: got free=%0d of=%0b want %0d 0", free_count, overflow_err, NUM);
        end
        ret0_valid = 1'b1; ret0_id = 9'd7;
        #1;
        n_cmp++;
        if (ret0_ready !== 1'b0) begin
            n_bad++; $display("FAIL overflow_grant: got ready=%0b want 0", ret0_ready);
        end
        tick();
        ret0_valid = 1'b0;
        n_cmp++;
        if (overflow_err !== 1'b1 || free_count !== NUM) begin
            n_bad++; $display("FAIL overflow: got of=%0b free=%0d want 1 %0d", overflow_err, free_count, NUM);
        end
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        n_cmp++;
        if (underflow_err !== 1'b0 || overflow_err !== 1'b0 || min_free !== NUM) begin
            n_bad++; $display("FAIL clr_stats: got uf=%0b of=%0b min=%0d want 0 0 %0d", underflow_err, overflow_err, min_free, NUM);
        end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b1;
        repeat (10) tick();
        #2 rst_n = 1'b0;
        #1;
        out_ready = 1'b0;
        n_cmp++;
        if ({init_done, out_valid, out_data, free_count, underflow_err, overflow_err} !== '0 || min_free !== NUM) begin
            n_bad++; $display("FAIL reset_async: got init=%0b valid=%0b data=%0d free=%0d min=%0d want 0 0 0 0 %0d",
                              init_done, out_valid, out_data, free_count, min_free, NUM);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (NUM + 1) tick();
        n_cmp++;
        if (init_done !== 1'b1 || out_valid !== 1'b1 || out_data !== 9'd0 || free_count !== NUM) begin
            n_bad++; $display("FAIL reinit: got done=%0b valid=%0b data=%0d free=%0d want 1 1 0 %0d",
                              init_done, out_valid, out_data, free_count, NUM);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (out_data !== 9'd1 || free_count !== NUM - 1) begin
            n_bad++; $display("FAIL reinit_pop: got data=%0d free=%0d want 1 %0d", out_data, free_count, NUM - 1);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_drain();
        test_refill();
        test_arbitration();
        test_concurrent();
        test_errors();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
